// File: rtl/dither_dac_tx.sv
// Dither polarity to DAC code converter with 3-wire serial DAC transmitter.
// Optional macro DAC_FRAME_CMD_EN prefixes every frame with command byte 8'h30.
module dither_dac_tx #(
  parameter int DAC_W   = 16,
  parameter int CLK_DIV = 2,
  parameter int CS_IDLE = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_trig,
  input  logic signed [31:0] i_dither,
  input  logic [DAC_W-1:0]   i_amp,
  input  logic [DAC_W-1:0]   i_offset,
  output logic               o_dac_cs_n,
  output logic               o_dac_sclk,
  output logic               o_dac_sdi,
  output logic               o_busy,
  output logic [DAC_W-1:0]   o_code,
  output logic               o_done,
  output logic [15:0]        o_drop_cnt
);

`ifdef DAC_FRAME_CMD_EN
  localparam int FW = DAC_W + 8;
`else
  localparam int FW = DAC_W;
`endif
  localparam int CW = 16;
  localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF      = CW'(CLK_DIV);
  localparam logic [CW-1:0] BIT_LAST  = CW'(2*CLK_DIV - 1);
  localparam logic [CW-1:0] IDLE_LAST = CW'(CS_IDLE - 1);
  localparam logic [CW-1:0] FW_LAST   = CW'(FW - 1);

  typedef enum logic [2:0] {IDLE, CALC, ASSERT, SHIFT, DEASSERT} state_t;

  state_t             state, nxt;
  logic signed [31:0] last_dither;
  logic               pending;
  logic [CW-1:0]      cnt;
  logic [CW-1:0]      bit_cnt;
  logic [FW-1:0]      sr;
  logic               req;
  logic               last_deassert;
  logic [DAC_W-1:0]   code_sat;
  logic [FW-1:0]      frame_load;
  logic signed [DAC_W+1:0] off_s, amp_s, sum_s;

  assign req           = i_trig | (i_dither != last_dither);
  assign last_deassert = (state == DEASSERT) && (cnt == IDLE_LAST);

  // Two guard bits: one for the carry of offset+amp, one for the sign of offset-amp.
  always_comb begin
    off_s = $signed({2'b00, i_offset});
    amp_s = $signed({2'b00, i_amp});
    sum_s = off_s;
    if (i_dither == 32'sd1)       sum_s = off_s + amp_s;
    else if (i_dither == -32'sd1) sum_s = off_s - amp_s;
    if (sum_s[DAC_W+1])    code_sat = '0;
    else if (sum_s[DAC_W]) code_sat = '1;
    else                   code_sat = sum_s[DAC_W-1:0];
  end

`ifdef DAC_FRAME_CMD_EN
  assign frame_load = {8'h30, code_sat};
`else
  assign frame_load = code_sat;
`endif

  always_comb begin
    nxt = state;
    case (state)
      IDLE:     if (req || pending) nxt = CALC;
      CALC:     nxt = ASSERT;
      ASSERT:   if (cnt == DIV_LAST) nxt = SHIFT;
      SHIFT:    if (cnt == BIT_LAST && bit_cnt == FW_LAST) nxt = DEASSERT;
      DEASSERT: if (cnt == IDLE_LAST) nxt = (req || pending) ? CALC : IDLE;
      default:  nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      last_dither <= '0;
      cnt         <= '0;
      bit_cnt     <= '0;
      sr          <= '0;
      o_code      <= '0;
    end else begin
      state       <= nxt;
      last_dither <= i_dither;
      case (state)
        CALC: begin
          o_code  <= code_sat;
          sr      <= frame_load;
          cnt     <= '0;
          bit_cnt <= '0;
        end
        ASSERT:   cnt <= (cnt == DIV_LAST) ? '0 : cnt + CW'(1);
        SHIFT: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            sr      <= {sr[FW-2:0], 1'b0};
            bit_cnt <= bit_cnt + CW'(1);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DEASSERT: cnt <= (cnt == IDLE_LAST) ? '0 : cnt + CW'(1);
        default:  cnt <= '0;
      endcase
    end
  end

  // A request landing on the last DEASSERT cycle while one is pending
  // becomes the next pending request rather than a drop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pending    <= 1'b0;
      o_drop_cnt <= '0;
    end else if (state == IDLE) begin
      pending <= 1'b0;
    end else if (last_deassert) begin
      pending <= pending & req;
    end else if (req) begin
      if (pending) begin
        if (o_drop_cnt != 16'hFFFF) o_drop_cnt <= o_drop_cnt + 16'd1;
      end else begin
        pending <= 1'b1;
      end
    end
  end

  assign o_busy     = (state != IDLE);
  assign o_dac_cs_n = !(state == ASSERT || state == SHIFT);
  assign o_dac_sclk = (state == SHIFT) && (cnt >= HALF);
  assign o_dac_sdi  = (state == ASSERT || state == SHIFT) ? sr[FW-1] : 1'b0;
  assign o_done     = last_deassert;

endmodule

// File: tb/tb_dither_dac_tx.sv
// Table-driven and randomized bench for dither_dac_tx; frames are decoded off the DAC pins.
module tb_dither_dac_tx;

`ifdef DAC_FRAME_CMD_EN
  localparam int FW = 24, FLEN = 101, CSLOW = 98;
`else
  localparam int FW = 16, FLEN = 69, CSLOW = 66;
`endif

  logic               clk, rst_n, trig;
  logic signed [31:0] dither;
  logic [15:0]        amp, offset;
  logic               cs_n, sclk, sdi, busy, done;
  logic [15:0]        code, drop_cnt;

  int n_vec = 0, n_err = 0;

  dither_dac_tx dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_trig(trig), .i_dither(dither),
    .i_amp(amp), .i_offset(offset), .o_dac_cs_n(cs_n), .o_dac_sclk(sclk),
    .o_dac_sdi(sdi), .o_busy(busy), .o_code(code), .o_done(done),
    .o_drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]        off;
    logic [15:0]        amp;
    logic signed [31:0] dit;
    logic               trg;
    logic [15:0]        code;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model(input int off, input int a, input int d);
    int v;
    v = off;
    if (d == 1) v = off + a;
    else if (d == -1) v = off - a;
    if (v < 0) v = 0;
    if (v > 65535) v = 65535;
    return 16'(v);
  endfunction

  function automatic logic [FW-1:0] exp_frame(input logic [15:0] c);
`ifdef DAC_FRAME_CMD_EN
    return {8'h30, c};
`else
    return c;
`endif
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Follows one frame from its CALC cycle (n=1) to the done pulse, decoding SDI on SCLK rises.
  task automatic capture(input int pulses, output logic [FW-1:0] frm,
                         output int cyc, output int cslow, output int nb);
    logic prev;
    int np;
    frm = '0; cyc = 0; cslow = 0; nb = 0; prev = 1'b0; np = 0;
    for (int n = 1; n <= 400; n++) begin
      tick();
      trig = 1'b0;
      if (!cs_n) cslow++;
      if (sclk && !prev) begin
        frm = {frm[FW-2:0], sdi};
        nb++;
      end
      prev = sclk;
      if (np < pulses && n % 10 == 0) begin
        trig = 1'b1;
        np++;
      end
      if (done) begin
        cyc = n;
        break;
      end
    end
  endtask

  task automatic check_frame(input string name, input logic [15:0] exp_code,
                             input int pulses);
    logic [FW-1:0] frm;
    int cyc, cslow, nb;
    capture(pulses, frm, cyc, cslow, nb);
    chk({name, " frame"}, 32'(frm), 32'(exp_frame(exp_code)));
    chk({name, " code"}, 32'(code), 32'(exp_code));
    chk({name, " len"}, 32'(cyc), 32'(FLEN));
    chk({name, " cs_low"}, 32'(cslow), 32'(CSLOW));
    chk({name, " bits"}, 32'(nb), 32'(FW));
  endtask

  task automatic run_vec(input string name, input logic [15:0] o, input logic [15:0] a,
                         input logic signed [31:0] d, input logic t, input logic [15:0] exp_code);
    offset = o; amp = a; dither = d; trig = t;
    check_frame(name, exp_code, 0);
    tick();
  endtask

  initial begin
    int k;
    logic [15:0] ro, ra;
    logic signed [31:0] rd;
    logic signed [31:0] dsel[6];

    tbl[0] = '{16'd32768, 16'd1000,  32'sd1,  1'b0, 16'h83E8};
    tbl[1] = '{16'd32768, 16'd1000, -32'sd1,  1'b0, 16'h7C18};
    tbl[2] = '{16'd32768, 16'd1000,  32'sd0,  1'b0, 16'h8000};
    tbl[3] = '{16'd65000, 16'd1000,  32'sd1,  1'b0, 16'hFFFF};
    tbl[4] = '{16'd500,   16'd1000, -32'sd1,  1'b0, 16'h0000};
    tbl[5] = '{16'd0,     16'd0,     32'sd0,  1'b0, 16'h0000};
    tbl[6] = '{16'd65535, 16'd65535, 32'sd1,  1'b0, 16'hFFFF};
    tbl[7] = '{16'd1234,  16'd0,     32'sd7,  1'b0, 16'h04D2};
    tbl[8] = '{16'd1234,  16'd5000,  32'sd7,  1'b1, 16'h04D2};
    tbl[9] = '{16'd100,   16'd40000, 32'sd1,  1'b0, 16'h9CA4};
    dsel = '{32'sd1, -32'sd1, 32'sd0, 32'sd1, -32'sd1, 32'sd3};

    rst_n = 1'b0; trig = 1'b0; dither = '0; amp = '0; offset = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst cs_n", 32'(cs_n), 32'd1);
    chk("rst sclk", 32'(sclk), 32'd0);
    chk("rst sdi", 32'(sdi), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst code", 32'(code), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst drop", 32'(drop_cnt), 32'd0);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("idle busy", 32'(busy), 32'd0);

    // Amp/offset changes alone must not start a frame.
    amp = 16'd77; offset = 16'd999;
    repeat (5) tick();
    chk("no frame on amp", 32'(busy), 32'd0);

    for (int i = 0; i < 10; i++)
      run_vec($sformatf("tbl%0d", i), tbl[i].off, tbl[i].amp, tbl[i].dit, tbl[i].trg, tbl[i].code);

    // One trig starts a frame, two more during it: one pending frame, one drop.
    offset = 16'd32768; amp = 16'd1000; trig = 1'b1;
    check_frame("b2b first", 16'h83E8, 2);
    check_frame("b2b second", 16'h83E8, 0);
    tick();
    chk("b2b idle", 32'(busy), 32'd0);
    chk("b2b drop", 32'(drop_cnt), 32'd1);

    for (int i = 0; i < 24; i++) begin
      ro = 16'($urandom);
      ra = 16'($urandom);
      rd = dsel[$urandom_range(0, 5)];
      run_vec($sformatf("rnd%0d", i), ro, ra, rd, 1'b1, model(int'(ro), int'(ra), int'(rd)));
    end

    // Hold trig high to flood requests until the drop counter saturates.
    trig = 1'b1;
    k = 0;
    while (drop_cnt != 16'hFFFF && k < 80000) begin
      tick();
      k++;
    end
    chk("drop reach max", 32'(drop_cnt), 32'hFFFF);
    repeat (150) tick();
    chk("drop saturated", 32'(drop_cnt), 32'hFFFF);
    trig = 1'b0;
    k = 0;
    while (busy && k < 500) begin
      tick();
      k++;
    end
    chk("drain idle", 32'(busy), 32'd0);

    // Reset asserted in the high half of bit 7 of SHIFT.
    offset = 16'd32768; amp = 16'd1000; dither = dither + 32'sd1;
    for (int n = 1; n <= 34; n++) tick();
    chk("pre-rst sclk", 32'(sclk), 32'd1);
    chk("pre-rst cs_n", 32'(cs_n), 32'd0);
    dither = '0;
    rst_n = 1'b0;
    #1;
    chk("mid-rst cs_n", 32'(cs_n), 32'd1);
    chk("mid-rst sclk", 32'(sclk), 32'd0);
    chk("mid-rst busy", 32'(busy), 32'd0);
    chk("mid-rst code", 32'(code), 32'd0);
    chk("mid-rst drop", 32'(drop_cnt), 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("post-rst idle", 32'(busy), 32'd0);
    run_vec("post-rst", 16'd32768, 16'd1000, -32'sd1, 1'b0, 16'h7C18);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
